// File: rtl/reverb_schroeder_param.sv
// Schroeder reverb: four parallel feedback combs, a comb average, then two
// series allpasses and an output mode mux. Each stage is registered, and the
// whole pipeline advances only on sampleValid.

// Circular delay line with one write pointer. A fill counter masks reads to
// zero until D samples have been written, so storage needs no reset.
module reverb_dline #(
  parameter int W = 20,
  parameter int D = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic signed [W-1:0] wdata,
  output logic signed [W-1:0] rdata
);
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic signed [W-1:0] mem [D];
  logic [AW-1:0]       wp_q;
  logic [CW-1:0]       cnt_q;

  // Pointer wraps D-1 -> 0; the fill count saturates at D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else if (en) begin
      wp_q <= (wp_q == AW'(D - 1)) ? '0 : wp_q + AW'(1);
      if (cnt_q != CW'(D)) cnt_q <= cnt_q + CW'(1);
    end
  end

  // Storage is deliberately left out of reset; the fill count hides stale data.
  always_ff @(posedge clk) begin
    if (en) mem[wp_q] <= wdata;
  end

  // The slot about to be overwritten holds the sample written D samples ago.
  assign rdata = (cnt_q == CW'(D)) ? mem[wp_q] : '0;
endmodule

module reverb_schroeder_param #(
  parameter int WIDTH   = 20,
  parameter int COMB_D0 = 1116,
  parameter int COMB_D1 = 1188,
  parameter int COMB_D2 = 1277,
  parameter int COMB_D3 = 1356,
  parameter int AP_D0   = 556,
  parameter int AP_D1   = 441
) (
  input  logic                    CLOCK48kHz,
  input  logic                    RESET,
  input  logic                    sampleValid,
  input  logic signed [WIDTH-1:0] audioIn,
  input  logic [15:0]             combGain,
  input  logic [15:0]             apGain,
  input  logic [1:0]              mode,
  output logic signed [WIDTH-1:0] audioOut,
  output logic                    outValid
);
  localparam int XW = WIDTH + 2;

  // Sign-extend a sample to the wide intermediate width.
  function automatic logic signed [XW-1:0] ext(input logic signed [WIDTH-1:0] x);
    return XW'(x);
  endfunction

  // Clamp a wide value back to WIDTH bits; the top three bits agree when it fits.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v[XW-1:WIDTH-1] == 3'b000 || v[XW-1:WIDTH-1] == 3'b111)
      return v[WIDTH-1:0];
    else if (v[XW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Signed sample times unsigned Q0.16 gain, floored by the arithmetic shift.
  function automatic logic signed [XW-1:0] mulg(input logic signed [WIDTH-1:0] x,
                                                input logic [15:0] g);
    logic signed [WIDTH+16:0] p;
    p = (WIDTH+17)'(x) * (WIDTH+17)'($signed({1'b0, g}));
    return XW'(p >>> 16);
  endfunction

  logic signed [WIDTH-1:0] comb_q [4];
  logic signed [WIDTH-1:0] comb_d [4];
  logic signed [WIDTH-1:0] comb_fb [4];
  logic signed [WIDTH-1:0] avg_q, avg_d;
  logic signed [WIDTH-1:0] ap_in [2];
  logic signed [WIDTH-1:0] ap_v [2];
  logic signed [WIDTH-1:0] ap_vd [2];
  logic signed [WIDTH-1:0] ap_y [2];
  logic signed [WIDTH-1:0] ap_q [2];
  logic signed [WIDTH-1:0] dry_q [4];
  logic signed [WIDTH-1:0] out_d;

  // Feedback combs: y = sat(x + g_c * y[n-D]).
  for (genvar k = 0; k < 4; k++) begin : g_comb
    localparam int CD = (k == 0) ? COMB_D0 : (k == 1) ? COMB_D1 :
                        (k == 2) ? COMB_D2 : COMB_D3;
    assign comb_d[k] = sat(ext(audioIn) + mulg(comb_fb[k], combGain));
    reverb_dline #(.W(WIDTH), .D(CD)) u_dl (
      .clk(CLOCK48kHz), .rst_n(RESET), .en(sampleValid),
      .wdata(comb_d[k]), .rdata(comb_fb[k])
    );
  end

  assign avg_d = sat((ext(comb_q[0]) + ext(comb_q[1]) + ext(comb_q[2]) + ext(comb_q[3])) >>> 2);

  assign ap_in[0] = avg_q;
  assign ap_in[1] = ap_q[0];

  // Allpasses: v = sat(x + g_a*v[n-D]), y = sat(v[n-D] - g_a*v).
  for (genvar a = 0; a < 2; a++) begin : g_ap
    localparam int AD = (a == 0) ? AP_D0 : AP_D1;
    assign ap_v[a] = sat(ext(ap_in[a]) + mulg(ap_vd[a], apGain));
    assign ap_y[a] = sat(ext(ap_vd[a]) - mulg(ap_v[a], apGain));
    reverb_dline #(.W(WIDTH), .D(AD)) u_dl (
      .clk(CLOCK48kHz), .rst_n(RESET), .en(sampleValid),
      .wdata(ap_v[a]), .rdata(ap_vd[a])
    );
  end

  // Output select; the dry tap is four samples old so it lines up with wet.
  always_comb begin
    out_d = ap_q[1];
    case (mode)
      2'b00:   out_d = audioIn;
      2'b10:   out_d = sat((ext(dry_q[3]) + ext(ap_q[1])) >>> 1);
      default: out_d = ap_q[1];
    endcase
  end

  // Pipeline registers, dry alignment line and output; all hold without sampleValid.
  always_ff @(posedge CLOCK48kHz or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 4; i++) begin
        comb_q[i] <= '0;
        dry_q[i]  <= '0;
      end
      avg_q    <= '0;
      ap_q[0]  <= '0;
      ap_q[1]  <= '0;
      audioOut <= '0;
      outValid <= 1'b0;
    end else begin
      outValid <= sampleValid;
      if (sampleValid) begin
        for (int i = 0; i < 4; i++) comb_q[i] <= comb_d[i];
        dry_q[0] <= audioIn;
        for (int i = 1; i < 4; i++) dry_q[i] <= dry_q[i-1];
        avg_q    <= avg_d;
        ap_q[0]  <= ap_y[0];
        ap_q[1]  <= ap_y[1];
        audioOut <= out_d;
      end
    end
  end
endmodule
